gps_ack_peak: RTL and testbench

Peak detector and result reporter for the GPS acquisition engine's correlation output interface. It captures each correlation result set (eight satellite channels of I/Q integrator values plus the shared code phase, code NCO fraction and Doppler) and computes the energy I²+Q² per channel. It keeps the per-channel maximum and its search coordinates. When the search completes, it streams one peak record per channel over a valid/ready handshake to the tracking-handover logic.

---
 rtl/gps_ack_peak.sv | 257 +++++++++++++++++++++++++
 tb/tb_gps_ack_peak.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_ack_peak.sv
// gps_ack_peak: tracks per-channel correlation energy peaks across a search and
// reports one peak record per channel over valid/ready when the search completes.
module gps_ack_peak #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned INT_W  = 14,
    parameter int unsigned THRESH = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     search_start,
    input  logic                     corr_complete,
    input  logic                     search_complete,
    input  logic [NUM_CH*6-1:0]      sat,
    input  logic [NUM_CH*INT_W-1:0]  integrator_i,
    input  logic [NUM_CH*INT_W-1:0]  integrator_q,
    input  logic [9:0]               code_phase,
    input  logic [4:0]               code_nco_frac,
    input  logic [15:0]              doppler_omega,
    output logic                     busy,
    output logic [7:0]               drop_cnt,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [2:0]               result_ch,
    output logic [5:0]               result_sat,
    output logic [9:0]               result_code_phase,
    output logic [4:0]               result_frac,
    output logic [15:0]              result_doppler,
    output logic [2*INT_W-1:0]       result_mag,
    output logic                     result_detect,
    output logic                     report_done
);
    localparam int unsigned MAG_W  = 2 * INT_W;
    localparam int unsigned SQ_W   = 2 * INT_W - 1;
    localparam int unsigned PROD_W = 2 * INT_W;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned CNT_W  = CH_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0] state, state_d;
    logic       corr_q, search_q, pending;
    logic       corr_edge, search_edge;
    logic       start_scan, start_report, report_last;
    logic       feed_en, scan_last, accept, ld_en;
    logic [CH_W-1:0] ld_idx, feed_idx;

    // snapshot of the captured correlation set
    logic        [5:0]       snap_sat [NUM_CH];
    logic signed [INT_W-1:0] snap_i   [NUM_CH];
    logic signed [INT_W-1:0] snap_q   [NUM_CH];
    logic [9:0]  snap_cp;
    logic [4:0]  snap_frac;
    logic [15:0] snap_dop;

    // peak table
    logic [MAG_W-1:0] pk_mag  [NUM_CH];
    logic [5:0]       pk_sat  [NUM_CH];
    logic [9:0]       pk_cp   [NUM_CH];
    logic [4:0]       pk_frac [NUM_CH];
    logic [15:0]      pk_dop  [NUM_CH];

    // energy pipeline
    logic [CNT_W-1:0] feed_cnt;
    logic             a_vld, b_vld;
    logic [CH_W-1:0]  a_ch, b_ch;
    logic [SQ_W-1:0]  a_i2, a_q2;
    logic [MAG_W-1:0] b_mag;

    assign corr_edge   = corr_complete & ~corr_q;
    assign search_edge = search_complete & ~search_q;
    assign feed_idx    = feed_cnt[CH_W-1:0];
    assign feed_en     = (state == S_SCAN) && (feed_cnt < CNT_W'(NUM_CH));
    assign scan_last   = (state == S_SCAN) && b_vld && (b_ch == CH_W'(NUM_CH - 1));
    assign accept      = (state == S_REPORT) && result_valid && result_ready;
    assign ld_en       = start_report || (accept && !report_last);
    assign ld_idx      = start_report ? CH_W'(0) : result_ch + CH_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // next state; search_start overrides everything, a same-cycle corr edge still scans
    always_comb begin
        state_d      = state;
        start_scan   = 1'b0;
        start_report = 1'b0;
        report_last  = 1'b0;
        if (search_start) begin
            if (corr_edge) begin
                state_d    = S_SCAN;
                start_scan = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (corr_edge) begin
                        state_d    = S_SCAN;
                        start_scan = 1'b1;
                    end else if (search_edge) begin
                        state_d      = S_REPORT;
                        start_report = 1'b1;
                    end
                end
                S_SCAN: begin
                    if (scan_last) begin
                        if (pending || search_edge) begin
                            state_d      = S_REPORT;
                            start_report = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_REPORT: begin
                    if (accept && (result_ch == CH_W'(NUM_CH - 1))) begin
                        state_d     = S_IDLE;
                        report_last = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // edge history, pending search and drop counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_q   <= 1'b0;
            search_q <= 1'b0;
            pending  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            corr_q   <= corr_complete;
            search_q <= search_complete;
            if (search_start || start_report)         pending <= 1'b0;
            else if (search_edge && state_d == S_SCAN) pending <= 1'b1;
            if (search_start)
                drop_cnt <= 8'd0;
            else if (corr_edge && state != S_IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                snap_sat[c] <= '0;
                snap_i[c]   <= '0;
                snap_q[c]   <= '0;
            end
            snap_cp   <= '0;
            snap_frac <= '0;
            snap_dop  <= '0;
        end else if (start_scan) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                snap_sat[c] <= sat[c*6 +: 6];
                snap_i[c]   <= integrator_i[c*INT_W +: INT_W];
                snap_q[c]   <= integrator_q[c*INT_W +: INT_W];
            end
            snap_cp   <= code_phase;
            snap_frac <= code_nco_frac;
            snap_dop  <= doppler_omega;
        end
    end

    // squares fit SQ_W unsigned bits, their sum fits MAG_W without overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feed_cnt <= '0;
            a_vld    <= 1'b0;
            a_ch     <= '0;
            a_i2     <= '0;
            a_q2     <= '0;
            b_vld    <= 1'b0;
            b_ch     <= '0;
            b_mag    <= '0;
        end else if (start_scan || search_start) begin
            feed_cnt <= '0;
            a_vld    <= 1'b0;
            b_vld    <= 1'b0;
        end else begin
            a_vld <= feed_en;
            if (feed_en) begin
                feed_cnt <= feed_cnt + CNT_W'(1);
                a_ch     <= feed_idx;
                a_i2     <= SQ_W'(PROD_W'(snap_i[feed_idx]) * PROD_W'(snap_i[feed_idx]));
                a_q2     <= SQ_W'(PROD_W'(snap_q[feed_idx]) * PROD_W'(snap_q[feed_idx]));
            end
            b_vld <= a_vld;
            if (a_vld) begin
                b_ch  <= a_ch;
                b_mag <= MAG_W'(a_i2) + MAG_W'(a_q2);
            end
        end
    end

    // strict greater-than keeps the earliest coordinates on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                pk_mag[c]  <= '0;
                pk_sat[c]  <= '0;
                pk_cp[c]   <= '0;
                pk_frac[c] <= '0;
                pk_dop[c]  <= '0;
            end
        end else if (search_start) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                pk_mag[c]  <= '0;
                pk_sat[c]  <= '0;
                pk_cp[c]   <= '0;
                pk_frac[c] <= '0;
                pk_dop[c]  <= '0;
            end
        end else if (b_vld && (b_mag > pk_mag[b_ch])) begin
            pk_mag[b_ch]  <= b_mag;
            pk_sat[b_ch]  <= snap_sat[b_ch];
            pk_cp[b_ch]   <= snap_cp;
            pk_frac[b_ch] <= snap_frac;
            pk_dop[b_ch]  <= snap_dop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy              <= 1'b0;
            result_valid      <= 1'b0;
            report_done       <= 1'b0;
            result_ch         <= '0;
            result_sat        <= '0;
            result_code_phase <= '0;
            result_frac       <= '0;
            result_doppler    <= '0;
            result_mag        <= '0;
            result_detect     <= 1'b0;
        end else begin
            busy         <= (state_d == S_SCAN);
            result_valid <= (state_d == S_REPORT);
            report_done  <= report_last;
            if (ld_en) begin
                result_ch         <= ld_idx;
                result_sat        <= pk_sat[ld_idx];
                result_code_phase <= pk_cp[ld_idx];
                result_frac       <= pk_frac[ld_idx];
                result_doppler    <= pk_dop[ld_idx];
                result_mag        <= pk_mag[ld_idx];
                result_detect     <= (pk_mag[ld_idx] >= MAG_W'(THRESH));
            end
        end
    end

endmodule

// File: tb/tb_gps_ack_peak.sv
// Randomized bench for gps_ack_peak against an arithmetic peak-table model.
module tb_gps_ack_peak;
    localparam int     NUM_CH = 8;
    localparam int     INT_W  = 14;
    localparam int     MAG_W  = 2 * INT_W;
    localparam longint THRESH = 1000000;

    logic clk = 1'b0;
    logic rst, search_start, corr_complete, search_complete, result_ready;
    logic [NUM_CH*6-1:0]     sat;
    logic [NUM_CH*INT_W-1:0] integrator_i, integrator_q;
    logic [9:0]  code_phase;
    logic [4:0]  code_nco_frac;
    logic [15:0] doppler_omega;
    logic        busy, result_valid, result_detect, report_done;
    logic [7:0]  drop_cnt;
    logic [2:0]  result_ch;
    logic [5:0]  result_sat;
    logic [9:0]  result_code_phase;
    logic [4:0]  result_frac;
    logic [15:0] result_doppler;
    logic [MAG_W-1:0] result_mag;

    always #5 clk = ~clk;

    gps_ack_peak dut (
        .clk(clk), .rst(rst), .search_start(search_start), .corr_complete(corr_complete),
        .search_complete(search_complete), .sat(sat), .integrator_i(integrator_i),
        .integrator_q(integrator_q), .code_phase(code_phase), .code_nco_frac(code_nco_frac),
        .doppler_omega(doppler_omega), .busy(busy), .drop_cnt(drop_cnt),
        .result_valid(result_valid), .result_ready(result_ready), .result_ch(result_ch),
        .result_sat(result_sat), .result_code_phase(result_code_phase),
        .result_frac(result_frac), .result_doppler(result_doppler), .result_mag(result_mag),
        .result_detect(result_detect), .report_done(report_done)
    );

    int total = 0;
    int bad   = 0;

    // stimulus set and reference peak table
    int in_i [NUM_CH];
    int in_q [NUM_CH];
    int in_sat [NUM_CH];
    int in_cp, in_frac, in_dop;
    longint m_mag [NUM_CH];
    int m_sat [NUM_CH];
    int m_cp [NUM_CH];
    int m_frac [NUM_CH];
    int m_dop [NUM_CH];

    // records gathered from the report stream
    logic [MAG_W-1:0] g_mag [NUM_CH];
    logic [5:0]  g_sat [NUM_CH];
    logic [9:0]  g_cp [NUM_CH];
    logic [4:0]  g_frac [NUM_CH];
    logic [15:0] g_dop [NUM_CH];
    logic        g_det [NUM_CH];
    int g_first_cyc, g_done_cyc, g_done_cnt, g_hold_bad, g_order_bad, g_nrec;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mag[c] = 0; m_sat[c] = 0; m_cp[c] = 0; m_frac[c] = 0; m_dop[c] = 0;
        end
    endfunction

    function automatic void model_apply();
        for (int c = 0; c < NUM_CH; c++) begin
            longint e = longint'(in_i[c]) * in_i[c] + longint'(in_q[c]) * in_q[c];
            if (e > m_mag[c]) begin
                m_mag[c] = e; m_sat[c] = in_sat[c]; m_cp[c] = in_cp;
                m_frac[c] = in_frac; m_dop[c] = in_dop;
            end
        end
    endfunction

    function automatic void zero_set();
        for (int c = 0; c < NUM_CH; c++) begin
            in_i[c] = 0; in_q[c] = 0; in_sat[c] = int'($urandom_range(0, 63));
        end
        in_cp = 0; in_frac = 0; in_dop = 0;
    endfunction

    function automatic void rand_set();
        for (int c = 0; c < NUM_CH; c++) begin
            in_i[c]   = int'($urandom_range(0, 16383)) - 8192;
            in_q[c]   = int'($urandom_range(0, 16383)) - 8192;
            in_sat[c] = int'($urandom_range(0, 63));
        end
        in_cp   = int'($urandom_range(0, 1023));
        in_frac = int'($urandom_range(0, 31));
        in_dop  = int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic logic [65:0] exp_word(input int c);
        logic det;
        det = (m_mag[c] >= THRESH);
        return {28'(m_mag[c]), 6'(m_sat[c]), 10'(m_cp[c]), 5'(m_frac[c]), 16'(m_dop[c]), det};
    endfunction

    function automatic logic [65:0] got_word(input int c);
        return {g_mag[c], g_sat[c], g_cp[c], g_frac[c], g_dop[c], g_det[c]};
    endfunction

    function automatic logic [68:0] rec_now();
        return {result_ch, result_sat, result_code_phase, result_frac, result_doppler,
                result_mag, result_detect};
    endfunction

    task automatic drive_set();
        for (int c = 0; c < NUM_CH; c++) begin
            sat[c*6 +: 6]                = 6'(in_sat[c]);
            integrator_i[c*INT_W +: INT_W] = INT_W'(in_i[c]);
            integrator_q[c*INT_W +: INT_W] = INT_W'(in_q[c]);
        end
        code_phase    = 10'(in_cp);
        code_nco_frac = 5'(in_frac);
        doppler_omega = 16'(in_dop);
    endtask

    task automatic pulse_corr();
        drive_set();
        corr_complete = 1'b1;
        step();
        corr_complete = 1'b0;
    endtask

    task automatic pulse_search();
        search_complete = 1'b1;
        step();
        search_complete = 1'b0;
    endtask

    task automatic clear_all();
        search_start = 1'b1;
        step();
        search_start = 1'b0;
        model_clear();
    endtask

    // drains one report, stalling ready on stall_ch for stall_n cycles; cycle 0 is the call cycle
    task automatic collect(input int stall_ch, input int stall_n);
        int stalled = 0;
        int extra = 0;
        bit done_seen = 1'b0;
        logic [68:0] hold_ref = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            g_mag[c] = 'x; g_sat[c] = 'x; g_cp[c] = 'x; g_frac[c] = 'x; g_dop[c] = 'x; g_det[c] = 'x;
        end
        g_first_cyc = -1; g_done_cyc = -1; g_done_cnt = 0; g_hold_bad = 0; g_order_bad = 0; g_nrec = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (report_done === 1'b1) begin
                if (!done_seen) g_done_cyc = cyc;
                done_seen = 1'b1;
                g_done_cnt++;
            end
            result_ready = 1'b0;
            if (result_valid === 1'b1) begin
                if (g_first_cyc < 0) g_first_cyc = cyc;
                if (int'(result_ch) == stall_ch && stalled < stall_n) begin
                    if (stalled == 0) hold_ref = rec_now();
                    else if (rec_now() !== hold_ref) g_hold_bad++;
                    stalled++;
                end else begin
                    if (int'(result_ch) == stall_ch && stalled > 0 && rec_now() !== hold_ref) g_hold_bad++;
                    if (int'(result_ch) != g_nrec) g_order_bad++;
                    result_ready = 1'b1;
                    g_mag[result_ch] = result_mag; g_sat[result_ch] = result_sat;
                    g_cp[result_ch] = result_code_phase; g_frac[result_ch] = result_frac;
                    g_dop[result_ch] = result_doppler; g_det[result_ch] = result_detect;
                    g_nrec++;
                end
            end
            step();
            if (done_seen) begin
                extra++;
                if (extra > 4) break;
            end
        end
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [68:0] rec;
        rst = 1'b1; search_start = 0; corr_complete = 0; search_complete = 0; result_ready = 0;
        zero_set(); drive_set();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        step();
        rec = rec_now();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        total++; if (report_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", report_done); end
        total++; if (rec !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", rec); end
    endtask

    task automatic test_single();
        logic [11:1] btrace;
        zero_set();
        in_i[3] = 100; in_q[3] = -50; in_cp = 517; in_frac = 9; in_dop = -80;
        pulse_corr();
        for (int k = 1; k <= 11; k++) begin
            btrace[k] = busy;
            if (k < 11) step();
        end
        model_apply();
        total++; if (btrace !== 11'b01111111111) begin bad++; $display("FAIL single_busy_trace got=%b exp=%b", btrace, 11'b01111111111); end
        step();
        pulse_search();
        collect(-1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL single_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
        total++; if (g_mag[3] !== 28'd12500) begin bad++; $display("FAIL single_mag3 got=%0d exp=12500", g_mag[3]); end
        total++; if (g_first_cyc != 0) begin bad++; $display("FAIL single_first_valid got=%0d exp=0", g_first_cyc); end
        total++; if (g_done_cyc != NUM_CH) begin bad++; $display("FAIL single_done_cyc got=%0d exp=%0d", g_done_cyc, NUM_CH); end
        total++; if (g_done_cnt != 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", g_done_cnt); end
        total++; if (g_order_bad != 0) begin bad++; $display("FAIL single_order got=%0d exp=0", g_order_bad); end
    endtask

    task automatic test_strict_max();
        logic [36:0] first_coords;
        rand_set(); in_i[0] = 300; in_q[0] = 400;
        first_coords = {6'(in_sat[0]), 10'(in_cp), 5'(in_frac), 16'(in_dop)};
        search_start = 1'b1;
        pulse_corr();
        search_start = 1'b0;
        model_clear(); model_apply();
        repeat (11) step();
        rand_set(); in_i[0] = 400; in_q[0] = 300;
        pulse_corr(); model_apply();
        repeat (11) step();
        rand_set(); in_i[0] = 100; in_q[0] = 0;
        pulse_corr(); model_apply();
        repeat (11) step();
        pulse_search();
        collect(-1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL strict_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
        total++; if ({g_sat[0], g_cp[0], g_frac[0], g_dop[0]} !== first_coords) begin
            bad++; $display("FAIL strict_ch0_coords got=%h exp=%h", {g_sat[0], g_cp[0], g_frac[0], g_dop[0]}, first_coords);
        end
        total++; if (g_mag[0] !== 28'd250000) begin bad++; $display("FAIL strict_ch0_mag got=%0d exp=250000", g_mag[0]); end
    endtask

    task automatic test_extremes();
        clear_all();
        rand_set();
        for (int c = 0; c < NUM_CH; c++) begin in_i[c] = -8192; in_q[c] = -8192; end
        pulse_corr(); model_apply();
        repeat (11) step();
        pulse_search();
        collect(-1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL extreme_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
        total++; if ({g_mag[7], g_det[7]} !== {28'd134217728, 1'b1}) begin
            bad++; $display("FAIL extreme_ch7 got=%0d/%b exp=134217728/1", g_mag[7], g_det[7]);
        end
    endtask

    task automatic test_random();
        int sc, sn;
        clear_all();
        for (int r = 0; r < 5; r++) begin
            rand_set();
            pulse_corr(); model_apply();
            repeat ($urandom_range(11, 15)) step();
        end
        sc = int'($urandom_range(0, NUM_CH - 1));
        sn = int'($urandom_range(1, 3));
        pulse_search();
        collect(sc, sn);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL random_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
        total++; if (g_hold_bad != 0) begin bad++; $display("FAIL random_hold got=%0d exp=0", g_hold_bad); end
        total++; if (g_done_cyc != NUM_CH + sn) begin bad++; $display("FAIL random_done_cyc got=%0d exp=%0d", g_done_cyc, NUM_CH + sn); end
    endtask

    task automatic test_drops();
        int m_drop;
        clear_all();
        m_drop = 0;
        rand_set();
        pulse_corr(); model_apply();
        step(); step();
        rand_set();
        pulse_corr(); m_drop++;
        total++; if (drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL drop_single got=%0d exp=%0d", drop_cnt, m_drop); end
        repeat (8) step();
        pulse_search();
        for (int k = 0; k < 300; k++) begin
            rand_set();
            pulse_corr();
            if (m_drop < 255) m_drop++;
            step();
        end
        total++; if (drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL drop_saturate got=%0d exp=%0d", drop_cnt, m_drop); end
        total++; if ({result_valid, result_ch} !== 4'b1000) begin bad++; $display("FAIL drop_report_held got=%b/%0d exp=1/0", result_valid, result_ch); end
        collect(-1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL drop_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
    endtask

    task automatic test_search_during_scan();
        logic [11:3] vtrace;
        clear_all();
        rand_set();
        pulse_corr(); model_apply();
        step();
        pulse_search();
        for (int k = 3; k <= 11; k++) begin
            vtrace[k] = result_valid;
            if (k < 11) step();
        end
        total++; if (vtrace !== 9'b100000000) begin bad++; $display("FAIL scan_search_valid_trace got=%b exp=%b", vtrace, 9'b100000000); end
        collect(2, 5);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL scan_search_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
        total++; if (g_hold_bad != 0) begin bad++; $display("FAIL scan_search_hold got=%0d exp=0", g_hold_bad); end
        total++; if (g_done_cnt != 1) begin bad++; $display("FAIL scan_search_done_cnt got=%0d exp=1", g_done_cnt); end
        total++; if (g_done_cyc != NUM_CH + 5) begin bad++; $display("FAIL scan_search_done_cyc got=%0d exp=%0d", g_done_cyc, NUM_CH + 5); end
    endtask

    task automatic test_abort_rst();
        logic [81:0] outs;
        clear_all();
        rand_set();
        pulse_corr(); model_apply();
        repeat (11) step();
        pulse_search();
        result_ready = 1'b1;
        repeat (3) step();
        result_ready = 1'b0;
        total++; if ({result_valid, result_ch} !== 4'b1011) begin bad++; $display("FAIL rst_pre got=%b/%0d exp=1/3", result_valid, result_ch); end
        #2 rst = 1'b1;
        #1;
        outs = {busy, drop_cnt, report_done, result_valid, rec_now()};
        total++; if (outs !== '0) begin bad++; $display("FAIL rst_async_outputs got=%h exp=0", outs); end
        step();
        rst = 1'b0;
        model_clear();
        step();
        pulse_search();
        collect(-1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL rst_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
    endtask

    task automatic test_abort_start();
        clear_all();
        rand_set();
        pulse_corr(); model_apply();
        step();
        pulse_corr();
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL start_pre_drop got=%0d exp=1", drop_cnt); end
        step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_pre_busy got=%b exp=1", busy); end
        clear_all();
        total++; if ({busy, result_valid, drop_cnt} !== 10'd0) begin
            bad++; $display("FAIL start_abort got=busy%b valid%b drop%0d exp=0/0/0", busy, result_valid, drop_cnt);
        end
        repeat (10) step();
        pulse_search();
        collect(-1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            total++; if (got_word(c) !== exp_word(c)) begin bad++; $display("FAIL start_rec%0d got=%h exp=%h", c, got_word(c), exp_word(c)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strict_max();
        test_extremes();
        test_random();
        test_drops();
        test_search_during_scan();
        test_abort_rst();
        test_abort_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
